// File: rtl/event_encoder8.sv
// event_encoder8: collects up to eight event request lines into a pending
// register and drains them as 3-bit binary codes via a registered
// valid/ready output stage. Selection is lowest-index-first, or round-robin
// starting after the last granted code when ROUND_ROBIN=1.
module event_encoder8 #(
   parameter int ROUND_ROBIN = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] code,
   output logic [7:0] pending,
   output logic       overflow
);

   // Registered state.
   logic [7:0] r_pending;
   logic       r_valid;
   logic [2:0] r_code;
   logic       r_overflow;
   logic [2:0] r_ptr;

   // Combinational helpers.
   logic [7:0] w_req_en;
   logic [7:0] w_cand;
   logic       w_slot_free;
   logic       w_load;
   logic [2:0] w_start;
   logic [2:0] w_idx;
   logic [7:0] w_sel;
   logic [7:0] w_pending_nxt;
   logic       w_dup;

   // First set bit of cand, scanning upward from start and wrapping mod 8.
   // With start=0 this is plain lowest-index-first priority.
   function automatic logic [2:0] f_select(input logic [7:0] cand,
                                           input logic [2:0] start);
      logic [2:0] idx;
      logic [2:0] pick;
      logic       found;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = start + 3'(k);
         if (!found && cand[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Candidate set, grant decision and next pending value.
   always_comb begin
      w_req_en    = en ? req : 8'h00;
      // New requests bypass the pending register so they can be granted on
      // the same edge they arrive.
      w_cand      = r_pending | w_req_en;
      w_slot_free = !r_valid || out_ready;
      w_load      = w_slot_free && (w_cand != 8'h00);
      w_start     = (ROUND_ROBIN != 0) ? r_ptr : 3'd0;
      w_idx       = f_select(w_cand, w_start);
      w_sel       = w_load ? (8'd1 << w_idx) : 8'd0;
      // A granted pending bit is cleared but re-arms if requested again; a
      // bypassed request granted immediately is never stored.
      w_pending_nxt = (r_pending & ~w_sel) | (w_req_en & ~(w_sel & ~r_pending));
      // A request hitting a bit that is still pending (and not being granted
      // right now) is merged and flagged.
      w_dup       = |(w_req_en & r_pending & ~w_sel);
   end

   // Output stage, pending register and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_code     <= 3'd0;
         r_pending  <= 8'h00;
         r_overflow <= 1'b0;
      end else begin
         if (w_slot_free) begin
            r_valid <= w_load;
            if (w_load) begin
               r_code <= w_idx;
            end
         end
         r_pending <= w_pending_nxt;
         if (w_dup) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Round-robin pointer: next search starts one past the last grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 3'd0;
      end else if (w_load) begin
         r_ptr <= w_idx + 3'd1;
      end
   end

   assign out_valid = r_valid;
   assign code      = r_code;
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule
